// File: rtl/debounce_timer_bank.sv
// debounce_timer_bank: bank of NUM_CH programmable interval timers sharing one
// prescaler. Each channel supports periodic or one-shot operation, a live
// terminal count, synchronous restart, a one-clk done pulse and count readback.
// Optional feature macro: TIMER_IRQ_EN adds irq_mask/irq_clr inputs, a sticky
// per-channel status and a single masked interrupt output.
module debounce_timer_bank #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned COUNTER_WIDTH  = 16,
    parameter int unsigned PRESCALE       = 1,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 ch_en,
    input  logic [NUM_CH-1:0]                 ch_restart,
    input  logic [NUM_CH-1:0]                 ch_mode,
    input  logic [NUM_CH*COUNTER_WIDTH-1:0]   final_value,
`ifdef TIMER_IRQ_EN
    input  logic [NUM_CH-1:0]                 irq_mask,
    input  logic [NUM_CH-1:0]                 irq_clr,
    output logic                              irq,
`endif
    output logic [NUM_CH-1:0]                 ch_done,
    output logic [NUM_CH-1:0]                 ch_expired,
    output logic [NUM_CH*COUNTER_WIDTH-1:0]   ch_count
);

    localparam logic [PRESCALE_WIDTH-1:0] PRESC_LAST = PRESCALE_WIDTH'(PRESCALE - 1);

    typedef enum logic {
        ST_RUN,
        ST_EXPIRED
    } state_t;

    logic [PRESCALE_WIDTH-1:0] presc;
    logic                      any_en;
    logic                      tick;

    assign any_en = |ch_en;
    assign tick   = any_en && (presc == PRESC_LAST);

    // Shared prescaler: free-runs while any channel is enabled, parks at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!any_en || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [COUNTER_WIDTH-1:0] fv;
        logic [COUNTER_WIDTH-1:0] term_m1;
        logic [COUNTER_WIDTH-1:0] cnt;
        logic                     done;
        state_t                   state;

        assign fv = final_value[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        // A zero terminal behaves as one, so the last count value is 0 in both cases.
        assign term_m1 = (fv == '0) ? '0 : fv - 1'b1;

        // Channel FSM: restart beats enable beats hold; EXPIRED is sticky until restart.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_RUN;
                cnt   <= '0;
                done  <= 1'b0;
            end else if (ch_restart[i]) begin
                state <= ST_RUN;
                cnt   <= '0;
                done  <= 1'b0;
            end else if (state == ST_EXPIRED) begin
                cnt  <= '0;
                done <= 1'b0;
            end else if (ch_en[i] && tick) begin
                // >= also catches a terminal lowered below the running count.
                if (cnt >= term_m1) begin
                    cnt  <= '0;
                    done <= 1'b1;
                    if (ch_mode[i]) begin
                        state <= ST_EXPIRED;
                    end
                end else begin
                    cnt  <= cnt + 1'b1;
                    done <= 1'b0;
                end
            end else begin
                done <= 1'b0;
            end
        end

        assign ch_done[i]                                  = done;
        assign ch_expired[i]                               = (state == ST_EXPIRED);
        assign ch_count[i*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt;
    end

`ifdef TIMER_IRQ_EN
    logic [NUM_CH-1:0] irq_status;
    logic [NUM_CH-1:0] irq_status_next;
    logic              irq_q;

    // Set wins over clear when a done pulse and a clear coincide.
    assign irq_status_next = ch_done | (irq_status & ~irq_clr);

    // Sticky status plus registered masked interrupt, built from the updated
    // status so irq follows an expiry by exactly one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_status <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_status <= irq_status_next;
            irq_q      <= |(irq_status_next & irq_mask);
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_debounce_timer_bank.sv
// Bench for debounce_timer_bank: two instances (PRESCALE 1 and 4) share the
// same stimulus and are compared every cycle against a behavioural model, plus
// a directed vector table and hand-written corner sequences.
module tb_debounce_timer_bank;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    ch_en, ch_restart, ch_mode;
    logic [NCH*CW-1:0] final_value;
    logic [NCH-1:0]    d0_done, d0_exp, d1_done, d1_exp;
    logic [NCH*CW-1:0] d0_cnt, d1_cnt;
`ifdef TIMER_IRQ_EN
    logic [NCH-1:0]    irq_mask, irq_clr;
    logic              d0_irq, d1_irq;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debounce_timer_bank #(.NUM_CH(NCH), .COUNTER_WIDTH(CW), .PRESCALE(1), .PRESCALE_WIDTH(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_restart(ch_restart), .ch_mode(ch_mode),
        .final_value(final_value),
`ifdef TIMER_IRQ_EN
        .irq_mask(irq_mask), .irq_clr(irq_clr), .irq(d0_irq),
`endif
        .ch_done(d0_done), .ch_expired(d0_exp), .ch_count(d0_cnt));

    debounce_timer_bank #(.NUM_CH(NCH), .COUNTER_WIDTH(CW), .PRESCALE(4), .PRESCALE_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_restart(ch_restart), .ch_mode(ch_mode),
        .final_value(final_value),
`ifdef TIMER_IRQ_EN
        .irq_mask(irq_mask), .irq_clr(irq_clr), .irq(d1_irq),
`endif
        .ch_done(d1_done), .ch_expired(d1_exp), .ch_count(d1_cnt));

    // Behavioural reference: prescaler phase and per-channel count as integers.
    int m_phase [2];
    int m_cnt   [2][NCH];
    bit m_done  [2][NCH];
    bit m_exp   [2][NCH];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0;
            for (int c = 0; c < NCH; c++) begin
                m_cnt[d][c] = 0; m_done[d][c] = 0; m_exp[d][c] = 0;
            end
        end
    endfunction

    function automatic void model_step(input int d, input int p);
        bit tick;
        int term;
        if (!rst_n) begin
            m_phase[d] = 0;
            for (int c = 0; c < NCH; c++) begin
                m_cnt[d][c] = 0; m_done[d][c] = 0; m_exp[d][c] = 0;
            end
            return;
        end
        // One tick every p enabled cycles; the phase restarts whenever all channels idle.
        m_phase[d] = (|ch_en) ? (m_phase[d] + 1) % p : 0;
        tick = (|ch_en) && (m_phase[d] == 0);
        for (int c = 0; c < NCH; c++) begin
            term = int'(final_value[c*CW +: CW]);
            if (term == 0) term = 1;
            if (ch_restart[c]) begin
                m_cnt[d][c] = 0; m_done[d][c] = 0; m_exp[d][c] = 0;
            end else if (m_exp[d][c]) begin
                m_done[d][c] = 0;
            end else if (ch_en[c] && tick) begin
                m_done[d][c] = (m_cnt[d][c] + 1 >= term);
                m_cnt[d][c]  = m_done[d][c] ? 0 : m_cnt[d][c] + 1;
                if (m_done[d][c] && ch_mode[c]) m_exp[d][c] = 1;
            end else begin
                m_done[d][c] = 0;
            end
        end
    endfunction

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0]    ed, ee;
        logic [NCH*CW-1:0] ec;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                ed[c] = m_done[d][c];
                ee[c] = m_exp[d][c];
                ec[c*CW +: CW] = CW'(m_cnt[d][c]);
            end
            if (d == 0) check("model_p1", {d0_done, d0_exp, d0_cnt}, {ed, ee, ec});
            else        check("model_p4", {d1_done, d1_exp, d1_cnt}, {ed, ee, ec});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, 1);
        model_step(1, 4);
        #1;
        compare_all();
    endtask

    task automatic wait_done(input int d, input int ch, input int max, output int n);
        n = 0;
        forever begin
            cycle();
            n++;
            if ((d == 0) ? d0_done[ch] : d1_done[ch]) break;
            if (n >= max) begin
                errors++; checks++;
                $display("FAIL wait_done: no done on dut%0d ch%0d within %0d cycles", d, ch, max);
                break;
            end
        end
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_p1", {d0_done, d0_exp, d0_cnt}, 72'd0);
        check("async_rst_p4", {d1_done, d1_exp, d1_cnt}, 72'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        en, rs, mode;
        logic [15:0] fin;
        int          cnt;
        logic        done, expd;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic en, rs, mode, input logic [15:0] fin,
                                input int cnt, input logic done, expd);
        vec_t v;
        v.en = en; v.rs = rs; v.mode = mode; v.fin = fin;
        v.cnt = cnt; v.done = done; v.expd = expd;
        tbl.push_back(v);
    endfunction

    initial begin
        int n;
        logic [15:0] fv;

        // Channel-0 vectors for the PRESCALE=1 instance: {en, restart, mode, final, count, done, expired}.
        for (int k = 1; k <= 14; k++) add(1, 0, 0, 5, k % 5, (k % 5) == 0, 0);
        add(1, 1, 0, 5, 0, 0, 0);                         // restart on the would-be expiry cycle
        add(1, 0, 0, 5, 1, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 5, 1, 0, 0); // disabled: hold
        add(1, 1, 0, 10, 0, 0, 0);
        for (int k = 1; k <= 7; k++) add(1, 0, 0, 10, k, 0, 0);
        add(1, 0, 0, 4, 0, 1, 0);                         // final lowered below count
        for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 0, 1, 0);  // final 0 -> every cycle
        add(0, 1, 0, 3, 0, 0, 0);
        add(1, 0, 0, 3, 1, 0, 0);
        add(1, 0, 0, 3, 2, 0, 0);
        add(1, 0, 1, 3, 0, 1, 1);                         // mode sampled at expiry
        for (int k = 0; k < 20; k++) add(1, 0, 0, 3, 0, 0, 1);
        add(0, 0, 0, 3, 0, 0, 1);
        add(1, 1, 1, 3, 0, 0, 0);
        add(1, 0, 1, 3, 1, 0, 0);
        add(1, 0, 1, 3, 2, 0, 0);
        add(1, 0, 1, 3, 0, 1, 1);
        add(1, 0, 1, 3, 0, 0, 1);

        rst_n = 1'b0; ch_en = '0; ch_restart = '0; ch_mode = '0; final_value = '0;
`ifdef TIMER_IRQ_EN
        irq_mask = '0; irq_clr = '0;
`endif
        model_reset();
        #12;
        check("reset_p1", {d0_done, d0_exp, d0_cnt}, 72'd0);
        check("reset_p4", {d1_done, d1_exp, d1_cnt}, 72'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            ch_en = {3'b000, tbl[i].en};
            ch_restart = {3'b000, tbl[i].rs};
            ch_mode = {3'b000, tbl[i].mode};
            final_value[15:0] = tbl[i].fin;
            cycle();
            check($sformatf("vec%0d", i), {64'd0, d0_done[0], d0_exp[0], d0_cnt[15:0]},
                  {64'd0, tbl[i].done, tbl[i].expd, 16'(tbl[i].cnt)});
        end

        // PRESCALE=4: ch3 final 2 -> period 8; a 5-cycle disable mid-prescale
        // clears the prescaler phase (2) so expiry comes 4 cycles after re-enable.
        ch_en = '0; ch_restart = '0; ch_mode = '0; final_value = '0;
        async_reset();
        final_value[3*CW +: CW] = 16'd2;
        ch_en = 4'b1000;
        wait_done(1, 3, 40, n);
        check("p4_first_period", 72'(n), 72'd8);
        wait_done(1, 3, 40, n);
        check("p4_second_period", 72'(n), 72'd8);
        for (int k = 0; k < 6; k++) cycle();
        ch_en = '0;
        for (int k = 0; k < 5; k++) cycle();
        check("p4_frozen_count", 72'(d1_cnt[3*CW +: CW]), 72'd1);
        ch_en = 4'b1000;
        wait_done(1, 3, 40, n);
        check("p4_after_pause", 72'(n), 72'd4);

        // Mid-count asynchronous reset.
        ch_en = 4'b1111;
        for (int k = 0; k < 3; k++) cycle();
        async_reset();
        ch_en = '0;

`ifdef TIMER_IRQ_EN
        final_value = '0;
        final_value[CW-1:0] = 16'd3;
        irq_mask = 4'b0001;
        ch_en = 4'b0001;
        wait_done(0, 0, 20, n);
        cycle();
        check("irq_set", 72'(d0_irq), 72'd1);
        wait_done(0, 0, 20, n);
        irq_clr = 4'b0001;
        cycle();
        check("irq_clr_vs_done", 72'(d0_irq), 72'd1);
        cycle();
        check("irq_clr_alone", 72'(d0_irq), 72'd0);
        irq_clr = '0;
        irq_mask = '0;
        ch_en = '0;
        cycle();
`endif

        // Randomized phase against the model, with occasional asynchronous resets.
        for (int c = 0; c < NCH; c++) final_value[c*CW +: CW] = 16'($urandom_range(0, 6));
        for (int k = 0; k < 600; k++) begin
            ch_en = 4'($urandom);
            ch_restart = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 7) == 0) ch_mode = 4'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                fv = 16'($urandom_range(0, 6));
                final_value[$urandom_range(0, NCH-1)*CW +: CW] = fv;
            end
            if (k % 200 == 199) async_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
